dut_responder: RTL
==================

Name: dut_responder

Overview:
- DUT-side end of the testbench DUT conduit.
- Accepts the driven operand pair (drive_a, drive_b) plus an operation select, computes the result, and returns it after a fixed, parameterised pipeline latency on dut_out.
- Serves as the reference arithmetic DUT for bring-up of driver/monitor/scoreboard, replacing ad-hoc delay registers.
- Optional fault injection gives the monitor deterministic errors to count.

Parameters:
WIDTH, 32, operand/result width in bits
LATENCY, 2, pipeline depth in clk_dut cycles; legal range 1..8
FAULT_PERIOD, 16, one faulted result every FAULT_PERIOD valid results (used only with the optional feature); legal range 2..2^16

Ports:
clk_dut  input  1  DUT clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
i_enable  input  1  pipeline advance; 0 freezes every stage, counter and output
i_valid  input  1  operands on i_drive_a/b are meaningful this cycle
i_op  input  2  operation: 00 add, 01 sub, 10 pass-a, 11 xor
i_drive_a  input  WIDTH  operand A
i_drive_b  input  WIDTH  operand B
o_dut_out  output  WIDTH  result
o_carry  output  1  add: carry-out; sub: borrow (A<B unsigned); pass/xor: 0
o_valid  output  1  o_dut_out/o_carry carry a real result
o_result_ctr  output  WIDTH  count of valid results emitted
o_fault  output  1  current o_dut_out was deliberately corrupted

Behaviour:
- Reset (reset==0, asynchronous):
  - All pipeline data, carry and valid bits go to 0.
  - o_dut_out=0, o_carry=0, o_valid=0, o_result_ctr=0, o_fault=0; internal fault counter=0.
  - Takes effect immediately, mid-pipeline included. In-flight results are discarded, not drained.
- Release is synchronous to the next clk_dut edge; the first capture happens on the first rising edge with reset==1.
- Stage 0 registers the computed result, carry and valid from inputs sampled at a rising edge with i_enable=1. Stages 1..LATENCY-1 shift.
- Latency: inputs sampled at enabled edge k appear on outputs after the LATENCY-th enabled edge counted from k inclusive (LATENCY=2 -> visible one cycle after the following edge).
- i_enable=0:
  - No stage updates; outputs hold.
  - o_result_ctr holds.
  - Inputs that cycle are ignored (not captured).
- i_valid=0 captures a bubble: data=0, carry=0, valid=0. Bubbles propagate and produce o_valid=0 with o_dut_out=0.
- Arithmetic:
  - Modulo 2^WIDTH, unsigned.
  - add: {carry,result} = A+B (WIDTH+1 bits).
  - sub: result = A-B mod 2^WIDTH; carry = (A<B).
  - pass-a: result = A, carry = 0.
  - xor: result = A^B, carry = 0.
- o_result_ctr increments by 1 on each rising edge where i_enable=1 and o_valid==1 (the result being replaced is counted). Wraps 2^WIDTH-1 -> 0 silently.
- Back-to-back valids at full rate are supported; no backpressure exists.
- o_fault is a pipeline sideband aligned with o_dut_out.

Optional Feature:
- Macro: DUT_RESPONDER_FAULT_EN.
- Defined:
  - A fault counter (16 bits) counts valid results entering the final stage.
  - When that result is the FAULT_PERIOD-th since reset or since the last fault, bit 0 of its data is inverted and o_fault=1 for it; the counter returns to 0.
  - Bubbles neither count nor fault. The counter freezes with i_enable=0.
- Not defined: no fault logic is synthesised; o_fault tied to 0; results always exact.

Test Plan:
- Reset, then LATENCY=2, i_enable=1, single valid add A=32'h0000_0005, B=32'h0000_0003 -> o_dut_out=8, o_carry=0, o_valid=1 for exactly one cycle, 2 edges after capture; o_result_ctr reads 1 after the next edge.
- Add 32'hFFFF_FFFF + 32'h0000_0002 -> o_dut_out=1, o_carry=1; sub 3-5 -> o_dut_out=32'hFFFF_FFFE, o_carry=1; xor CAFEF00D^FEEDC0DE -> 341330D3, o_carry=0.
- Stream 4 valid adds, drop i_enable for 3 cycles mid-stream -> outputs and o_result_ctr frozen during stall; after resume all 4 results emerge in order, none lost or duplicated; ctr=4.
- Pulse reset low asynchronously (between edges) with 2 results in flight -> outputs 0 immediately; no in-flight result ever appears; ctr=0.
- With DUT_RESPONDER_FAULT_EN, FAULT_PERIOD=4, 12 consecutive valid pass-a of A=32'h10 -> results 4, 8, 12 read 32'h11 with o_fault=1, all others 32'h10; without macro all 12 read 32'h10 and o_fault stays 0.
- Force o_result_ctr near wrap (WIDTH=4 build, 17 valid results) -> counter reads 1, no error.

Source files
------------

// File: rtl/dut_responder_if.sv
// dut_responder_if: operand/result conduit between the bench driver and dut_responder
// Signals:
//   i_enable, i_valid, i_op[1:0], i_drive_a/b[WIDTH-1:0]  driver -> DUT
//   o_dut_out[WIDTH-1:0], o_carry, o_valid,
//   o_result_ctr[WIDTH-1:0], o_fault                      DUT -> monitor
// Modports: master (driver side), slave (DUT side).
interface dut_responder_if #(
  parameter int WIDTH = 32
) ();
  logic             i_enable;
  logic             i_valid;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_drive_a;
  logic [WIDTH-1:0] i_drive_b;
  logic [WIDTH-1:0] o_dut_out;
  logic             o_carry;
  logic             o_valid;
  logic [WIDTH-1:0] o_result_ctr;
  logic             o_fault;
  modport master (
    output i_enable, i_valid, i_op, i_drive_a, i_drive_b,
    input  o_dut_out, o_carry, o_valid, o_result_ctr, o_fault
  );
  modport slave (
    input  i_enable, i_valid, i_op, i_drive_a, i_drive_b,
    output o_dut_out, o_carry, o_valid, o_result_ctr, o_fault
  );
endinterface

// File: rtl/dut_responder.sv
// dut_responder: reference arithmetic DUT returning op(A,B) after LATENCY enabled clk_dut edges
// Ports:
//   clk_dut  DUT clock, all state on rising edge
//   reset    asynchronous, active-low reset
//   bus      dut_responder_if.slave: i_enable, i_valid, i_op (00 add, 01 sub, 10 pass-a, 11 xor),
//            i_drive_a/b -> o_dut_out, o_carry, o_valid, o_result_ctr, o_fault
// Optional: define DUT_RESPONDER_FAULT_EN to invert bit 0 of every FAULT_PERIOD-th valid result.
module dut_responder #(
  parameter int WIDTH        = 32,
  parameter int LATENCY      = 2,
  parameter int FAULT_PERIOD = 16
) (
  input logic            clk_dut,
  input logic            reset,
  dut_responder_if.slave bus
);
  logic [WIDTH:0]                sum;
  logic [WIDTH-1:0]              res;
  logic                          cy;
  logic [WIDTH-1:0]              in_d;
  logic                          in_c;
  logic [LATENCY-1:0][WIDTH-1:0] pd;
  logic [LATENCY-1:0]            pc;
  logic [LATENCY-1:0]            pv;
  // stage inputs: index 0 is the freshly computed result, index i is stage i-1
  logic [LATENCY-1:0][WIDTH-1:0] dch;
  logic [LATENCY-1:0]            cch;
  logic [LATENCY-1:0]            vch;
  logic [WIDTH-1:0]              ctr;
  logic                          hit;
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("dut_responder: LATENCY must be 1..8");
  end
  if (FAULT_PERIOD < 2 || FAULT_PERIOD > 65536) begin : g_bad_period
    $error("dut_responder: FAULT_PERIOD must be 2..65536");
  end
  always_comb begin
    sum  = {1'b0, bus.i_drive_a} + {1'b0, bus.i_drive_b};
    res  = bus.i_op == 2'd0 ? sum[WIDTH-1:0] :
           bus.i_op == 2'd1 ? bus.i_drive_a - bus.i_drive_b :
           bus.i_op == 2'd2 ? bus.i_drive_a : bus.i_drive_a ^ bus.i_drive_b;
    cy   = bus.i_op == 2'd0 ? sum[WIDTH] :
           bus.i_op == 2'd1 ? bus.i_drive_a < bus.i_drive_b : 1'b0;
    in_d = bus.i_valid ? res : '0;
    in_c = bus.i_valid & cy;
  end
  if (LATENCY == 1) begin : g_chain1
    assign dch = in_d;
    assign cch = in_c;
    assign vch = bus.i_valid;
  end else begin : g_chain
    assign dch = {pd[LATENCY-2:0], in_d};
    assign cch = {pc[LATENCY-2:0], in_c};
    assign vch = {pv[LATENCY-2:0], bus.i_valid};
  end
`ifdef DUT_RESPONDER_FAULT_EN
  logic [15:0] fcnt;
  logic        flt;
  // 17-bit compare so FAULT_PERIOD = 65536 is reachable by a 16-bit counter
  assign hit = vch[LATENCY-1] && ({1'b0, fcnt} + 17'd1 == 17'(FAULT_PERIOD));
  assign bus.o_fault = flt;
`else
  assign hit = 1'b0;
  assign bus.o_fault = 1'b0;
`endif
  always_ff @(posedge clk_dut or negedge reset)
    if (!reset) begin
      pd  <= '0;
      pc  <= '0;
      pv  <= '0;
      ctr <= '0;
`ifdef DUT_RESPONDER_FAULT_EN
      fcnt <= '0;
      flt  <= 1'b0;
`endif
    end else if (bus.i_enable) begin
      for (int i = 0; i < LATENCY - 1; i++) begin
        pd[i] <= dch[i];
        pc[i] <= cch[i];
        pv[i] <= vch[i];
      end
      pd[LATENCY-1] <= dch[LATENCY-1] ^ WIDTH'(hit);
      pc[LATENCY-1] <= cch[LATENCY-1];
      pv[LATENCY-1] <= vch[LATENCY-1];
      // the result being replaced is the one counted
      ctr <= ctr + WIDTH'(pv[LATENCY-1]);
`ifdef DUT_RESPONDER_FAULT_EN
      flt  <= hit;
      fcnt <= hit ? '0 : fcnt + 16'(vch[LATENCY-1]);
`endif
    end
  assign bus.o_dut_out    = pd[LATENCY-1];
  assign bus.o_carry      = pc[LATENCY-1];
  assign bus.o_valid      = pv[LATENCY-1];
  assign bus.o_result_ctr = ctr;
endmodule
